// File: rtl/button_fifo_reader.sv
// Purpose: pops button events from the FIFO into a one-entry holding register read by the CPU.
// Latency: 2 cycles from empty falling (in IDLE) or consume (FIFO non-empty) to btn_valid=1.
// Backpressure: a held event blocks further pops until consume; pops never issue while empty=1.
// Ports: clk/rst (async active-low), FIFO read side (empty, rd_en, dout),
//        CPU side (consume, irq_en, btn_valid, btn_data, irq, event_count).
module button_fifo_reader #(
  parameter int DATA_WIDTH = 3,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  empty,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] dout,
  input  logic                  consume,
  input  logic                  irq_en,
  output logic                  btn_valid,
  output logic [DATA_WIDTH-1:0] btn_data,
  output logic                  irq,
  output logic [CNT_WIDTH-1:0]  event_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic                  btn_valid_q, btn_valid_d;
  logic [DATA_WIDTH-1:0] btn_data_q, btn_data_d;
  logic [CNT_WIDTH-1:0]  event_count_q, event_count_d;
  logic                  pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      btn_valid_q   <= 1'b0;
      btn_data_q    <= '0;
      event_count_q <= '0;
    end else begin
      state_q       <= state_d;
      btn_valid_q   <= btn_valid_d;
      btn_data_q    <= btn_data_d;
      event_count_q <= event_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    btn_valid_d   = btn_valid_q;
    btn_data_d    = btn_data_q;
    event_count_d = event_count_q;
    pop           = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = FETCH;
        end
      end

      // FIFO read data is registered, so it is valid exactly one cycle after the pop.
      FETCH: begin
        btn_data_d  = dout;
        btn_valid_d = 1'b1;
        state_d     = HOLD;
      end

      HOLD: begin
        if (consume) begin
          btn_valid_d   = 1'b0;
          btn_data_d    = '0;
          event_count_d = event_count_q + CNT_ONE;
          // Back-to-back pop: the next entry is requested in the release cycle,
          // leaving a single bubble cycle with btn_valid=0.
          if (!empty) begin
            pop     = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        btn_valid_d = 1'b0;
        btn_data_d  = '0;
      end
    endcase
  end

  // Reset gates the strobe directly so the FIFO never sees a pop while in reset.
  assign rd_en       = pop & rst;
  assign btn_valid   = btn_valid_q;
  assign btn_data    = btn_data_q;
  assign irq         = btn_valid_q & irq_en;
  assign event_count = event_count_q;

endmodule
